// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_MULU = 2'd1,
        OP_DIV  = 2'd2,
        OP_DIVU = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;

    // Quotient returned on divide by zero; the unit replicates bit 0 to its own WIDTH.
    localparam logic [DEF_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// Combinational single-bit restoring division step.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             next_bit,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor on entry, so a clear top bit of diff means the trial subtract fits
    assign shifted  = {rem, next_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide with hi/lo result.
// Optional MULDIV_FAST_MUL_EN: single-pass combinational multiply (IDLE -> FIX).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mul_start,
    input  logic             mulu_start,
    input  logic             div_start,
    input  logic             divu_start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    state_t             state;
    op_t                op;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;   // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opb;   // multiplicand or divisor magnitude
    logic               neg_lo;
    logic               neg_hi;

    logic               start;
    op_t                req_op;
    logic               req_signed;
    logic               req_div;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    always_comb begin
        start  = div_start | divu_start | mul_start | mulu_start;
        req_op = OP_MULU;
        if (div_start)       req_op = OP_DIV;
        else if (divu_start) req_op = OP_DIVU;
        else if (mul_start)  req_op = OP_MUL;
    end

    assign req_signed = (req_op == OP_MUL) || (req_op == OP_DIV);
    assign req_div    = (req_op == OP_DIV) || (req_op == OP_DIVU);
    assign mag_a      = (req_signed && a[WIDTH-1]) ? '0 - a : a;
    assign mag_b      = (req_signed && b[WIDTH-1]) ? '0 - b : b;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH:0]   mul_sum;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem      (acc[2*WIDTH-1:WIDTH]),
        .divisor  (opb),
        .next_bit (acc[WIDTH-1]),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};

    logic               is_mul;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] res;

    assign is_mul = (op == OP_MUL) || (op == OP_MULU);

`ifdef MULDIV_FAST_MUL_EN
    assign prod_mag = is_mul ? {{WIDTH{1'b0}}, opb} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc;
`else
    assign prod_mag = acc;
`endif

    // Sign fix-up; quotient and remainder are negated independently
    always_comb begin
        res = prod_mag;
        if (is_mul) begin
            if (neg_lo) res = '0 - prod_mag;
        end else begin
            res[2*WIDTH-1:WIDTH] = neg_hi ? '0 - acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            res[WIDTH-1:0]       = neg_lo ? '0 - acc[WIDTH-1:0]       : acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op     <= OP_MUL;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op     <= req_op;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        neg_lo <= req_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi <= req_signed & a[WIDTH-1];
                        opb    <= req_div ? mag_b : mag_a;
                        if (req_div && b == '0) begin
                            // Raw dividend to hi, all ones to lo, no sign fix-up
                            acc    <= {a, {WIDTH{DIV0_QUOT[0]}}};
                            neg_lo <= 1'b0;
                            neg_hi <= 1'b0;
                            state  <= FIX;
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, (req_div ? mag_a : mag_b)};
                            state <= (FAST_MUL && !req_div) ? FIX : CALC;
                        end
                    end
                end
                CALC: begin
                    if (is_mul) acc <= {mul_sum, acc[WIDTH-1:1]};
                    else        acc <= {step_rem, acc[WIDTH-2:0], step_q};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    hi    <= res[2*WIDTH-1:WIDTH];
                    lo    <= res[WIDTH-1:0];
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
